// File: rtl/neuron_spike_encoder_if.sv
// Event readout bus between the spike encoder and the logging stage.
// Valid/ready: the encoder raises ev_valid while the FIFO head holds an
// event and keeps every ev_* field stable until a cycle where
// ev_valid & ev_ready are both high; that cycle transfers the head.
// ev_ready may be driven without regard to ev_valid.
interface neuron_spike_encoder_if #(
   parameter int V_WIDTH   = 25,
   parameter int TS_WIDTH  = 32,
   parameter int ISI_WIDTH = 16
);
   logic                 ev_valid;
   logic                 ev_ready;
   logic [TS_WIDTH-1:0]  ev_ts;
   logic [ISI_WIDTH-1:0] ev_isi;
   logic [V_WIDTH-1:0]   ev_v;
   logic                 ev_first;

   modport master (
      output ev_valid, ev_ts, ev_isi, ev_v, ev_first,
      input  ev_ready
   );

   modport slave (
      input  ev_valid, ev_ts, ev_isi, ev_v, ev_first,
      output ev_ready
   );
endinterface

// File: rtl/neuron_spike_encoder.sv
// Spike encoder for the neuron model: detects the 1->0 edge of the
// neuron's select output, applies a refractory lockout, timestamps each
// spike, measures the inter-spike interval and queues events in a FIFO.
module neuron_spike_encoder #(
   parameter int V_WIDTH       = 25,
   parameter int TS_WIDTH      = 32,
   parameter int ISI_WIDTH     = 16,
   parameter int REFRAC_CYCLES = 4,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        sel_in,
   input  logic signed [V_WIDTH-1:0]   v_in,
   neuron_spike_encoder_if.master      ev,
   output logic                        spike_pulse,
   output logic                        refractory,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic [15:0]                 overflow_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = $clog2(REFRAC_CYCLES + 1);

   localparam logic [0:0] ARMED      = 1'b0;
   localparam logic [0:0] REFRACTORY = 1'b1;

   typedef struct packed {
      logic [TS_WIDTH-1:0]  ts;
      logic [ISI_WIDTH-1:0] isi;
      logic [V_WIDTH-1:0]   v;
      logic                 first;
   } event_t;

   logic [TS_WIDTH-1:0]  ts;
   logic [TS_WIDTH-1:0]  last_ts;
   logic [TS_WIDTH-1:0]  diff;
   logic                 sel_q;
   logic                 have_last;
   logic [0:0]           state;
   logic [RW-1:0]        refrac_cnt;
   logic [RW-1:0]        refrac_nxt;
   logic                 detect;
   logic [ISI_WIDTH-1:0] isi;
   event_t               mem [FIFO_DEPTH];
   event_t               head;
   event_t               wr_ev;
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 valid;
   logic                 full;
   logic                 pop;
   logic                 push;

   // A spike is the falling edge of sel while armed and the timebase runs.
   assign detect = en & sel_q & ~sel_in & (state == ARMED);

   assign fifo_count = wr_ptr - rd_ptr;
   assign valid      = (fifo_count != '0);
   assign full       = (fifo_count == (AW + 1)'(FIFO_DEPTH));
   assign pop        = valid & ev.ev_ready;
   // A full FIFO still takes the new event when the head leaves this cycle.
   assign push       = detect & (~full | pop);
   assign refractory = (state == REFRACTORY);

   assign diff = ts - last_ts;

   // ISI is the wrapped timestamp difference, clipped to the field width.
   always_comb begin
      isi = '1;
      if (have_last && ((diff >> ISI_WIDTH) == '0)) isi = ISI_WIDTH'(diff);
   end

   // Refractory counter only advances on enabled cycles.
   always_comb begin
      refrac_nxt = refrac_cnt;
      if (en && (refrac_cnt != '0)) refrac_nxt = refrac_cnt - RW'(1);
   end

   assign wr_ev.ts    = ts;
   assign wr_ev.isi   = isi;
   assign wr_ev.v     = v_in;
   assign wr_ev.first = ~have_last;

   assign head        = mem[rd_ptr[AW-1:0]];
   assign ev.ev_valid = valid;
   assign ev.ev_ts    = valid ? head.ts    : '0;
   assign ev.ev_isi   = valid ? head.isi   : '0;
   assign ev.ev_v     = valid ? head.v     : '0;
   assign ev.ev_first = valid ? head.first : 1'b0;

   // Free-running timebase and the sel history used for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts    <= '0;
         sel_q <= 1'b1;
      end else begin
         sel_q <= sel_in;
         if (en) ts <= ts + TS_WIDTH'(1);
      end
   end

   // Armed/refractory FSM; rearm waits for the count to expire and sel high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARMED;
         refrac_cnt <= '0;
      end else begin
         case (state)
            ARMED: begin
               if (detect) begin
                  state      <= REFRACTORY;
                  refrac_cnt <= RW'(REFRAC_CYCLES);
               end
            end
            default: begin
               refrac_cnt <= refrac_nxt;
               if ((refrac_nxt == '0) && sel_in) state <= ARMED;
            end
         endcase
      end
   end

   // Last-spike timestamp follows every detection, even a dropped one.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_ts   <= '0;
         have_last <= 1'b0;
      end else if (detect) begin
         last_ts   <= ts;
         have_last <= 1'b1;
      end
   end

   // FIFO pointers, spike strobe and the saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         spike_pulse  <= 1'b0;
         overflow_cnt <= '0;
      end else begin
         spike_pulse <= detect;
         if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
         if (detect && !push && (overflow_cnt != 16'hFFFF))
            overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   // Event storage; contents are masked by ev_valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wr_ev;
   end
endmodule
